// File: rtl/seg_digit_rx.sv
// Seven-segment digit receiver: debounces an active-low segment bus, decodes
// stable hex glyphs and hands them to a consumer with a valid/ready handshake.
module seg_digit_rx #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_L,
    input  logic       digit_ready,
    output logic       digit_valid,
    output logic [3:0] digit,
    output logic [7:0] pair,
    output logic       pattern_err
);

    typedef enum logic [1:0] {IDLE, FILTER, HOLD, WAIT} state_t;

    state_t     state;
    state_t     state_next;
    logic [6:0] s_reg;
    logic [6:0] cand;
    logic [6:0] glyph;
    logic [3:0] cnt;
    logic [3:0] decoded;
    logic       legal;
    logic       s_blank;
    logic       stable_hit;

    assign s_blank    = (s_reg == 7'h7F);
    assign glyph      = ~cand;
    assign stable_hit = (s_reg == cand) && (cnt == 4'(STABLE_CYCLES - 1));

    always_comb begin
        legal   = 1'b1;
        decoded = 4'h0;
        case (glyph)
            7'h3F: decoded = 4'h0;
            7'h06: decoded = 4'h1;
            7'h5B: decoded = 4'h2;
            7'h4F: decoded = 4'h3;
            7'h66: decoded = 4'h4;
            7'h6D: decoded = 4'h5;
            7'h7D: decoded = 4'h6;
            7'h07: decoded = 4'h7;
            7'h7F: decoded = 4'h8;
            7'h6F: decoded = 4'h9;
            7'h77: decoded = 4'hA;
            7'h7C: decoded = 4'hB;
            7'h39: decoded = 4'hC;
            7'h5E: decoded = 4'hD;
            7'h79: decoded = 4'hE;
            7'h71: decoded = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!s_blank) state_next = FILTER;
            end
            FILTER: begin
                if (s_blank)         state_next = IDLE;
                else if (stable_hit) state_next = legal ? HOLD : WAIT;
            end
            HOLD: begin
                if (digit_ready) state_next = WAIT;
            end
            WAIT: begin
                if (s_blank)            state_next = IDLE;
                else if (s_reg != cand) state_next = FILTER;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        digit_valid = (state == HOLD);
    end

    // cand doubles as the "last reported pattern" while in WAIT, so a held
    // glyph is only reported once until the bus changes or blanks.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg       <= 7'h7F;
            cand        <= 7'h7F;
            cnt         <= 4'd0;
            digit       <= 4'h0;
            pair        <= 8'h00;
            pattern_err <= 1'b0;
        end else begin
            s_reg       <= seg_L;
            pattern_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!s_blank) begin
                        cand <= s_reg;
                        cnt  <= 4'd1;
                    end
                end
                FILTER: begin
                    if (!s_blank) begin
                        if (s_reg != cand) begin
                            cand <= s_reg;
                            cnt  <= 4'd1;
                        end else begin
                            if (cnt != 4'hF) cnt <= cnt + 4'd1;
                            if (stable_hit) begin
                                if (legal) digit       <= decoded;
                                else       pattern_err <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (digit_ready) pair <= {pair[3:0], digit};
                end
                WAIT: begin
                    if (!s_blank && (s_reg != cand)) begin
                        cand <= s_reg;
                        cnt  <= 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_digit_rx.sv
// Scoreboard bench for seg_digit_rx: a run-length reference model predicts
// transfers and error pulses; a negedge monitor compares what the DUT shows.
module tb_seg_digit_rx;

    localparam int STABLE = 4;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_L;
    logic       digit_ready;
    logic       digit_valid;
    logic [3:0] digit;
    logic [7:0] pair;
    logic       pattern_err;

    int checks = 0;
    int passed = 0;
    int cycle  = 0;

    seg_digit_rx #(.STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_L       (seg_L),
        .digit_ready (digit_ready),
        .digit_valid (digit_valid),
        .digit       (digit),
        .pair        (pair),
        .pattern_err (pattern_err)
    );

    always #5 clk = ~clk;

    typedef enum {M_FREE, M_HOLD, M_SUPP} mmode_t;
    typedef struct packed {
        logic [3:0] d;
        logic [7:0] p;
    } xfer_t;

    mmode_t     mode    = M_FREE;
    logic [6:0] m_s     = 7'h7F;
    logic [6:0] run_val = 7'h7F;
    int         run_len = 0;
    logic [3:0] m_digit = 4'h0;
    logic [7:0] m_pair  = 8'h00;
    xfer_t      xfer_q[$];
    int         err_q[$];

    function automatic int glyph_index(logic [6:0] g);
        for (int i = 0; i < 16; i++) begin
            if (GLYPH[i] == g) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(string name, int actual, int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    endtask

    // Reference: count how long the registered sample has held one non-blank
    // value; STABLE in a row reports it, then the same value is ignored.
    task automatic model_edge();
        logic [6:0] x;
        int         idx;
        xfer_t      e;
        x = m_s;
        cycle++;
        if (rst) begin
            m_s     = 7'h7F;
            mode    = M_FREE;
            run_val = 7'h7F;
            run_len = 0;
            m_digit = 4'h0;
            m_pair  = 8'h00;
            return;
        end
        m_s = seg_L;
        case (mode)
            M_HOLD: begin
                if (digit_ready) begin
                    m_pair = {m_pair[3:0], m_digit};
                    e.d = m_digit;
                    e.p = m_pair;
                    xfer_q.push_back(e);
                    mode = M_SUPP;
                end
            end
            M_SUPP: begin
                if (x == 7'h7F) begin
                    mode    = M_FREE;
                    run_len = 0;
                end else if (x != run_val) begin
                    mode    = M_FREE;
                    run_val = x;
                    run_len = 1;
                end
            end
            default: begin
                if (x == 7'h7F) run_len = 0;
                else if (run_len > 0 && x == run_val) run_len++;
                else begin
                    run_val = x;
                    run_len = 1;
                end
                if (run_len == STABLE) begin
                    idx = glyph_index(~x);
                    if (idx >= 0) begin
                        m_digit = 4'(idx);
                        mode    = M_HOLD;
                    end else begin
                        err_q.push_back(cycle);
                        mode = M_SUPP;
                    end
                end
            end
        endcase
    endtask

    task automatic applyStimulus(logic [6:0] seg, logic ready, logic r);
        seg_L       = seg;
        digit_ready = ready;
        rst         = r;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    // Monitor: a handshake seen at one negedge is a transfer at the next
    // posedge, so the popped expectation is compared one negedge later.
    initial begin
        logic       prev_fire;
        logic [3:0] prev_digit;
        xfer_t      e;
        int         ec;
        prev_fire  = 1'b0;
        prev_digit = 4'h0;
        forever begin
            @(negedge clk);
            if (prev_fire) begin
                if (xfer_q.size() == 0) begin
                    checkOutput("unexpected_transfer", 1, 0);
                end else begin
                    e = xfer_q.pop_front();
                    checkOutput("xfer_digit", int'(prev_digit), int'(e.d));
                    checkOutput("xfer_pair", int'(pair), int'(e.p));
                end
            end
            checkOutput("digit_valid", int'(digit_valid), int'(mode == M_HOLD));
            if (digit_valid) checkOutput("held_digit", int'(digit), int'(m_digit));
            if (pattern_err) begin
                if (err_q.size() == 0) begin
                    checkOutput("unexpected_err", 1, 0);
                end else begin
                    ec = err_q.pop_front();
                    checkOutput("err_cycle", cycle, ec);
                end
            end
            prev_fire  = digit_valid && digit_ready && !rst;
            prev_digit = digit;
        end
    end

    task automatic doReset();
        applyStimulus(7'h7F, 1'b0, 1'b1);
        applyStimulus(7'h7F, 1'b0, 1'b1);
    endtask

    initial begin
        int         err_n;
        int         err_at;
        int         len;
        int         kind;
        logic [6:0] pat;
        logic [6:0] v;
        logic       rdy;

        doReset();
        checkOutput("reset_valid", int'(digit_valid), 0);
        checkOutput("reset_digit", int'(digit), 0);
        checkOutput("reset_pair", int'(pair), 0);
        checkOutput("reset_err", int'(pattern_err), 0);

        for (int i = 1; i <= 5; i++) begin
            applyStimulus(~7'h5B, 1'b1, 1'b0);
            if (i == 4) checkOutput("d2_not_early", int'(digit_valid), 0);
        end
        checkOutput("d2_valid", int'(digit_valid), 1);
        checkOutput("d2_digit", int'(digit), 2);
        applyStimulus(~7'h5B, 1'b1, 1'b0);
        checkOutput("d2_valid_drop", int'(digit_valid), 0);
        checkOutput("d2_pair", int'(pair), 8'h02);

        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(~7'h06, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(7'h7F, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(~7'h4F, 1'b1, 1'b0);
        checkOutput("seq_pair", int'(pair), 8'h13);
        checkOutput("seq_digit", int'(digit), 3);

        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(((i / 2) % 2 == 0) ? ~7'h6D : ~7'h7D, 1'b1, 1'b0);
        end
        checkOutput("toggle_valid", int'(digit_valid), 0);
        checkOutput("toggle_pair", int'(pair), 0);

        doReset();
        err_n  = 0;
        err_at = -1;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(~7'h49, 1'b1, 1'b0);
            if (pattern_err) begin
                err_n++;
                err_at = i;
            end
        end
        checkOutput("illegal_pulses", err_n, 1);
        checkOutput("illegal_edge", err_at, 5);

        doReset();
        for (int i = 1; i <= 13; i++) begin
            applyStimulus(~7'h77, 1'b0, 1'b0);
            if (i >= 5) begin
                checkOutput("bp_valid", int'(digit_valid), 1);
                checkOutput("bp_digit", int'(digit), 4'hA);
            end
        end
        applyStimulus(~7'h77, 1'b1, 1'b0);
        checkOutput("bp_pair", int'(pair), 8'h0A);
        for (int i = 0; i < 6; i++) applyStimulus(~7'h77, 1'b1, 1'b0);
        checkOutput("bp_no_recapture", int'(digit_valid), 0);
        checkOutput("bp_pair_once", int'(pair), 8'h0A);

        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(~7'h5B, 1'b1, 1'b0);
        applyStimulus(~7'h5B, 1'b1, 1'b1);
        checkOutput("rst_hold_valid", int'(digit_valid), 0);
        checkOutput("rst_hold_digit", int'(digit), 0);
        checkOutput("rst_hold_pair", int'(pair), 0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(~7'h5B, 1'b1, 1'b0);
            if (i == 4) checkOutput("recap_not_early", int'(digit_valid), 0);
        end
        checkOutput("recap_valid", int'(digit_valid), 1);

        pat = 7'h7F;
        for (int s = 0; s < 300; s++) begin
            kind = $urandom_range(0, 99);
            if (kind < 40) begin
                pat = ~GLYPH[$urandom_range(0, 15)];
            end else if (kind < 60) begin
                pat = 7'h7F;
            end else if (kind < 75) begin
                v = 7'(glyph_index(7'h00));
                do v = 7'($urandom_range(1, 127)); while (glyph_index(v) >= 0);
                pat = ~v;
            end
            len = $urandom_range(1, 7);
            for (int c = 0; c < len; c++) begin
                rdy = ($urandom_range(0, 3) != 0);
                applyStimulus(pat, rdy, ($urandom_range(0, 199) == 0));
            end
        end

        for (int i = 0; i < 8; i++) applyStimulus(7'h7F, 1'b1, 1'b0);
        checkOutput("xfer_queue_empty", xfer_q.size(), 0);
        checkOutput("err_queue_empty", err_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
